list_writer: RTL and testbench
==============================

# list_writer

Builds a singly linked list of 32-bit values in the dual-port RAM that the list-summing data path later walks. It accepts values over a valid/ready stream, allocates two-word nodes sequentially from a base address and drives the RAM write port. Each node is laid out as value at `addr`, next pointer at `addr+1`, with next = 0 as terminator, which is the layout the summing data path reads. It reports the list head and a completion pulse to the controlling FSM.

## Interface
- `ADDR_W`, 8, RAM address width; the RAM holds 2^ADDR_W words.
- `BASE_ADDR`, 2, address of the first node; must be nonzero and ≤ 2^ADDR_W−2.
- `clk`  input  1  clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  begin a new list; honoured only in IDLE.
- `in_valid`  input  1  `in_data`/`in_last` valid.
- `in_ready`  output  1  writer can accept an element.
- `in_data`  input  32  element value.
- `in_last`  input  1  element is the list tail.
- `we`  output  1  RAM write enable.
- `waddr`  output  ADDR_W  RAM write address.
- `wdata`  output  32  RAM write data.
- `head`  output  32  address of the first node, zero-extended.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse when the list is terminated.
- `overflow`  output  1  sticky: the list was truncated for lack of space.

## Operation
- States:
  - IDLE: `start` → ACCEPT. Also loads `ptr`←BASE_ADDR and `head`←BASE_ADDR, and clears `overflow`.
  - ACCEPT: `in_ready`=1. On `in_valid`, capture `in_data` and `in_last`, then → WR_VAL.
  - WR_VAL: `we`=1, `waddr`=ptr, `wdata`=captured value. → WR_NEXT.
  - WR_NEXT: `we`=1, `waddr`=ptr+1. `wdata` is chosen as follows:
    - Captured `last`: `wdata`=0 → DONE.
    - Else if ptr+3 > 2^ADDR_W−1 (no room for another node): `wdata`=0, set `overflow` → DONE.
    - Else: `wdata`=ptr+2 (zero-extended), `ptr`←ptr+2 → ACCEPT.
  - DONE: `done`=1, → IDLE.
- Outputs are Moore-decoded from the state register. `waddr`/`wdata` derive from registered `ptr`/data, and are 0 when `we`=0.
- `start` outside IDLE is ignored. `in_valid` outside ACCEPT is ignored, because `in_ready`=0 there.
- A list always has at least one node. An empty list is not representable, since head ≠ 0.
- Pointer arithmetic is ADDR_W bits wide. The overflow check prevents address wrap, so no write ever wraps to address 0.
- `head` and `overflow` hold their values after DONE until the next accepted `start` or `rst`.
- Reset mid-operation: the FSM returns to IDLE and no further writes occur. The partially written list in RAM is abandoned and is not terminated. The consumer must not walk it.

## Timing
- Reset values: `in_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `head`=0, `busy`=0, `done`=0, `overflow`=0; the state is IDLE.
- `start` sampled high at edge 0 gives ACCEPT from cycle 1.
- Handshake at edge N gives:
  - the value write in cycle N+1;
  - the next-pointer write in cycle N+2;
  - either ACCEPT again (`in_ready`=1) in cycle N+3, or `done`=1 in cycle N+3 and IDLE in cycle N+4.
- Throughput is one element per 3 cycles.
- Producer stall in ACCEPT: no writes occur, and the state and `ptr` hold.

## Test plan
- Three-element list, BASE_ADDR=2, values 5, 7, 9 (last on 9):
  - Writes are (2,5), (3,4), (4,7), (5,6), (6,9), (7,0), then one `done` pulse.
  - `head`=2, `overflow`=0.
  - Running the summing data path from head 2 gives sum 21.
- Single element 0xDEADBEEF with `in_last`=1:
  - Writes are (2,0xDEADBEEF), then (3,0), then `done`.
  - `busy` falls the cycle after `done`.
- Backpressure: `in_valid` held low for 4 cycles between elements.
  - `we` stays 0 and `in_ready` stays 1 throughout the gap.
  - Final RAM contents are identical to the first scenario.
- Overflow, ADDR_W=3, BASE_ADDR=2, four non-last elements 1, 2, 3, 4:
  - Writes are (2,1), (3,4), (4,2), (5,6), (6,3), (7,0), then `done` and `overflow`=1.
  - The fourth element is never accepted.
- `start` pulsed during WR_VAL is ignored.
  - After `done`, a new `start` resets `head` to 2 and clears `overflow`.
- `rst` asserted in WR_NEXT:
  - Next cycle: `we`=0, `busy`=0, `head`=0, `in_ready`=0, and no further writes occur.

Source files
------------

// File: rtl/list_writer.sv
// -----------------------------------------------------------------------------
// list_writer
//
// Builds a singly linked list of 32-bit values in a dual-port RAM, one
// two-word node per accepted element:
//    mem[addr]   = value
//    mem[addr+1] = next node address, 0 terminates the list
// Nodes are allocated back to back starting at BASE_ADDR. The list-summing
// data path later walks this layout starting from `head`.
//
// Parameters
//    ADDR_W     RAM address width (RAM holds 2^ADDR_W words)
//    BASE_ADDR  address of the first node, nonzero and <= 2^ADDR_W-2
//
// Ports
//    clk        clock, rising edge
//    rst        synchronous active-high reset
//    start      begin a new list (honoured only while idle)
//    in_valid   in_data / in_last valid
//    in_ready   writer can accept an element
//    in_data    element value
//    in_last    element is the list tail
//    we         RAM write enable
//    waddr      RAM write address (0 when we=0)
//    wdata      RAM write data    (0 when we=0)
//    head       address of the first node, zero-extended to 32 bits
//    busy       high whenever the FSM is not idle
//    done       one-cycle pulse once the list is terminated
//    overflow   sticky: list truncated because no room for another node
// -----------------------------------------------------------------------------
module list_writer #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic [31:0]       head,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ACCEPT  = 3'd1;
   localparam logic [2:0] S_WR_VAL  = 3'd2;
   localparam logic [2:0] S_WR_NEXT = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   // Highest RAM address, held one bit wider so the room check cannot wrap.
   localparam logic [ADDR_W:0]   MAX_ADDR = {1'b0, {ADDR_W{1'b1}}};

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q,   ptr_d;
   logic [ADDR_W-1:0] head_q,  head_d;
   logic [31:0]       data_q,  data_d;
   logic              last_q,  last_d;
   logic              ovf_q,   ovf_d;

   logic [ADDR_W-1:0] ptr_p1, ptr_p2;
   logic [ADDR_W:0]   ptr_p3;
   logic              no_room;

   assign ptr_p1 = ptr_q + ADDR_W'(1);
   assign ptr_p2 = ptr_q + ADDR_W'(2);
   assign ptr_p3 = {1'b0, ptr_q} + (ADDR_W+1)'(3);
   // The next node would need ptr+2 and ptr+3; refuse it if ptr+3 is beyond
   // the top of the RAM so the allocator never wraps back to address 0.
   assign no_room = (ptr_p3 > MAX_ADDR);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      head_d  = head_q;
      data_d  = data_q;
      last_d  = last_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ACCEPT;
               ptr_d   = BASE;
               head_d  = BASE;
               ovf_d   = 1'b0;
            end
         end
         S_ACCEPT: begin
            if (in_valid) begin
               data_d  = in_data;
               last_d  = in_last;
               state_d = S_WR_VAL;
            end
         end
         S_WR_VAL: begin
            state_d = S_WR_NEXT;
         end
         S_WR_NEXT: begin
            if (last_q) begin
               state_d = S_DONE;
            end else if (no_room) begin
               ovf_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               ptr_d   = ptr_p2;
               state_d = S_ACCEPT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         head_q  <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         head_q  <= head_d;
         data_q  <= data_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
      end
   end

   // ---------------------------------------------------------------------
   // Moore outputs
   // ---------------------------------------------------------------------
   always_comb begin
      in_ready = 1'b0;
      we       = 1'b0;
      waddr    = '0;
      wdata    = '0;
      done     = 1'b0;
      case (state_q)
         S_ACCEPT: begin
            in_ready = 1'b1;
         end
         S_WR_VAL: begin
            we    = 1'b1;
            waddr = ptr_q;
            wdata = data_q;
         end
         S_WR_NEXT: begin
            we    = 1'b1;
            waddr = ptr_p1;
            // Tail or truncated list gets the 0 terminator; otherwise link
            // to the node that will be allocated right after this one.
            if (!last_q && !no_room) begin
               wdata = 32'(ptr_p2);
            end
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign busy     = (state_q != S_IDLE);
   assign head     = 32'(head_q);
   assign overflow = ovf_q;

endmodule

// File: tb/tb_list_writer.sv
module tb_list_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, in_valid, in_last;
   logic [31:0] in_data;

   // DUT A: ADDR_W=8, DUT B: ADDR_W=3 (overflow corner)
   logic        in_ready_a, we_a, busy_a, done_a, ovf_a;
   logic [7:0]  waddr_a;
   logic [31:0] wdata_a, head_a;
   logic        in_ready_b, we_b, busy_b, done_b, ovf_b;
   logic [2:0]  waddr_b;
   logic [31:0] wdata_b, head_b;

   list_writer #(.ADDR_W(8), .BASE_ADDR(2)) u_a (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
      .we(we_a), .waddr(waddr_a), .wdata(wdata_a), .head(head_a),
      .busy(busy_a), .done(done_a), .overflow(ovf_a));

   list_writer #(.ADDR_W(3), .BASE_ADDR(2)) u_b (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
      .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .head(head_b),
      .busy(busy_b), .done(done_b), .overflow(ovf_b));

   // Selected DUT view
   logic        sel;
   logic        in_ready_m, we_m, busy_m, done_m, ovf_m;
   logic [7:0]  waddr_m;
   logic [31:0] wdata_m, head_m;
   assign in_ready_m = sel ? in_ready_b : in_ready_a;
   assign we_m       = sel ? we_b : we_a;
   assign busy_m     = sel ? busy_b : busy_a;
   assign done_m     = sel ? done_b : done_a;
   assign ovf_m      = sel ? ovf_b : ovf_a;
   assign waddr_m    = sel ? {5'b0, waddr_b} : waddr_a;
   assign wdata_m    = sel ? wdata_b : wdata_a;
   assign head_m     = sel ? head_b : head_a;

   int ntests = 0;
   int nfail  = 0;
   int ndone, hs;
   logic [31:0] ram [256];
   logic [7:0]  log_a[$], exp_a[$], s1_a[$];
   logic [31:0] log_d[$], exp_d[$], s1_d[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: count handshake before the edge, sample outputs #1 after it.
   task automatic tick();
      if (in_ready_m && in_valid) hs++;
      @(posedge clk);
      #1;
      if (we_m) begin
         log_a.push_back(waddr_m);
         log_d.push_back(wdata_m);
         ram[waddr_m] = wdata_m;
      end
      if (done_m) ndone++;
   endtask

   task automatic clr();
      log_a.delete(); log_d.delete(); exp_a.delete(); exp_d.delete();
      ndone = 0; hs = 0;
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
   endtask

   task automatic ew(input logic [7:0] a, input logic [31:0] d);
      exp_a.push_back(a);
      exp_d.push_back(d);
   endtask

   task automatic chk_log(input string tag);
      chk($sformatf("%s nwrites", tag), log_a.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() && i < log_a.size(); i++) begin
         chk($sformatf("%s waddr[%0d]", tag, i), {24'b0, log_a[i]}, {24'b0, exp_a[i]});
         chk($sformatf("%s wdata[%0d]", tag, i), log_d[i], exp_d[i]);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Wait for in_ready (bounded), idle for gap cycles, then hand over one element.
   task automatic send(input logic [31:0] v, input logic last, input int gap);
      int guard = 0;
      while (!in_ready_m && guard < 20) begin
         tick();
         guard++;
      end
      chk("send ready", {31'b0, in_ready_m}, 32'd1);
      for (int g = 0; g < gap; g++) begin
         chk("gap in_ready", {31'b0, in_ready_m}, 32'd1);
         chk("gap we", {31'b0, we_m}, 32'd0);
         tick();
      end
      in_valid = 1'b1;
      in_data  = v;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done();
      int guard = 0;
      while (ndone == 0 && guard < 20) begin
         tick();
         guard++;
      end
      chk("done seen", ndone, 32'd1);
   endtask

   initial begin
      logic [7:0]  p;
      logic [31:0] sum;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; sel = 1'b0;
      clr();
      tick(); tick();

      // Reset state
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #0;
         chk("rst in_ready", {31'b0, in_ready_m}, 32'd0);
         chk("rst we", {31'b0, we_m}, 32'd0);
         chk("rst waddr", {24'b0, waddr_m}, 32'd0);
         chk("rst wdata", wdata_m, 32'd0);
         chk("rst head", head_m, 32'd0);
         chk("rst busy", {31'b0, busy_m}, 32'd0);
         chk("rst done", {31'b0, done_m}, 32'd0);
         chk("rst overflow", {31'b0, ovf_m}, 32'd0);
      end
      sel = 1'b0;
      rst = 1'b0;
      tick();

      // Three-element list 5,7,9
      clr();
      do_start();
      chk("s1 in_ready after start", {31'b0, in_ready_m}, 32'd1);
      send(32'd5, 1'b0, 0);
      send(32'd7, 1'b0, 0);
      send(32'd9, 1'b1, 0);
      wait_done();
      tick();
      chk("s1 busy idle", {31'b0, busy_m}, 32'd0);
      ew(8'd2, 32'd5); ew(8'd3, 32'd4); ew(8'd4, 32'd7);
      ew(8'd5, 32'd6); ew(8'd6, 32'd9); ew(8'd7, 32'd0);
      chk_log("s1");
      chk("s1 ndone", ndone, 32'd1);
      chk("s1 head", head_m, 32'd2);
      chk("s1 overflow", {31'b0, ovf_m}, 32'd0);
      sum = 0;
      p = head_m[7:0];
      for (int k = 0; k < 16; k++) begin
         if (p != 8'd0) begin
            sum = sum + ram[p];
            p = ram[p + 8'd1][7:0];
         end
      end
      chk("s1 walk sum", sum, 32'd21);
      s1_a = log_a;
      s1_d = log_d;

      // Single element, cycle-exact
      clr();
      do_start();
      chk("s2 in_ready", {31'b0, in_ready_m}, 32'd1);
      in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      chk("s2 val we", {31'b0, we_m}, 32'd1);
      chk("s2 val waddr", {24'b0, waddr_m}, 32'd2);
      chk("s2 val wdata", wdata_m, 32'hDEADBEEF);
      tick();
      chk("s2 next we", {31'b0, we_m}, 32'd1);
      chk("s2 next waddr", {24'b0, waddr_m}, 32'd3);
      chk("s2 next wdata", wdata_m, 32'd0);
      tick();
      chk("s2 done", {31'b0, done_m}, 32'd1);
      chk("s2 busy in done", {31'b0, busy_m}, 32'd1);
      chk("s2 we in done", {31'b0, we_m}, 32'd0);
      tick();
      chk("s2 done drop", {31'b0, done_m}, 32'd0);
      chk("s2 busy drop", {31'b0, busy_m}, 32'd0);
      chk("s2 idle waddr", {24'b0, waddr_m}, 32'd0);
      chk("s2 idle wdata", wdata_m, 32'd0);
      chk("s2 idle in_ready", {31'b0, in_ready_m}, 32'd0);

      // Backpressure: 4 idle cycles between elements
      clr();
      do_start();
      send(32'd5, 1'b0, 0);
      send(32'd7, 1'b0, 4);
      send(32'd9, 1'b1, 4);
      wait_done();
      tick();
      exp_a = s1_a;
      exp_d = s1_d;
      chk_log("s3");

      // Overflow on the 8-word RAM
      sel = 1'b1;
      clr();
      do_start();
      chk("s4 overflow clear", {31'b0, ovf_m}, 32'd0);
      send(32'd1, 1'b0, 0);
      send(32'd2, 1'b0, 0);
      send(32'd3, 1'b0, 0);
      in_valid = 1'b1; in_data = 32'd4; in_last = 1'b0;
      wait_done();
      chk("s4 overflow in done", {31'b0, ovf_m}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("s4 handshakes", hs, 32'd3);
      ew(8'd2, 32'd1); ew(8'd3, 32'd4); ew(8'd4, 32'd2);
      ew(8'd5, 32'd6); ew(8'd6, 32'd3); ew(8'd7, 32'd0);
      chk_log("s4");
      chk("s4 overflow sticky", {31'b0, ovf_m}, 32'd1);
      chk("s4 head", head_m, 32'd2);
      chk("s4 busy", {31'b0, busy_m}, 32'd0);

      // start during WR_VAL ignored; new start clears overflow
      clr();
      do_start();
      chk("s5 overflow cleared", {31'b0, ovf_m}, 32'd0);
      chk("s5 head", head_m, 32'd2);
      send(32'd5, 1'b0, 0);
      chk("s5 in WR_VAL waddr", {24'b0, waddr_m}, 32'd2);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("s5 WR_NEXT waddr", {24'b0, waddr_m}, 32'd3);
      chk("s5 WR_NEXT wdata", wdata_m, 32'd4);
      send(32'd9, 1'b1, 0);
      wait_done();
      tick();
      ew(8'd2, 32'd5); ew(8'd3, 32'd4); ew(8'd4, 32'd9); ew(8'd5, 32'd0);
      chk_log("s5");
      chk("s5 head after", head_m, 32'd2);

      // Reset in WR_NEXT
      sel = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0; tick();
      clr();
      do_start();
      send(32'd5, 1'b0, 0);
      tick();
      chk("s6 WR_NEXT we", {31'b0, we_m}, 32'd1);
      chk("s6 WR_NEXT waddr", {24'b0, waddr_m}, 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("s6 we", {31'b0, we_m}, 32'd0);
      chk("s6 busy", {31'b0, busy_m}, 32'd0);
      chk("s6 head", head_m, 32'd0);
      chk("s6 in_ready", {31'b0, in_ready_m}, 32'd0);
      log_a.delete(); log_d.delete();
      in_valid = 1'b1; in_data = 32'd77;
      for (int k = 0; k < 4; k++) tick();
      in_valid = 1'b0;
      chk("s6 no writes", log_a.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
